instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit and instruction memory.
//   ImemReq   : fetch request valid (fetch unit -> memory)
//   ImemAddr  : word-aligned fetch address (fetch unit -> memory)
//   ImemRdata : fetched word, valid while ImemAck=1 (memory -> fetch unit)
//   ImemAck   : memory returns ImemRdata this cycle (memory -> fetch unit)
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic [31:0]       ImemRdata;
  logic              ImemAck;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemRdata,
    input  ImemAck
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemRdata,
    output ImemAck
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Front end of the pipelined MIPS core. Owns the PC, issues word fetches over
// a req/ack handshake and presents the fetched word, its PC and PC+4 through
// the registered IF/ID stage. Decode stalls are absorbed by a one-entry skid
// buffer; Redirect reloads the PC and flushes the stage with a NOP.
// Ports:
//   Clk, Rst          : rising-edge clock, asynchronous active-high reset
//   Stall             : decode cannot accept, IF/ID outputs hold
//   Redirect          : taken branch/jump, load RedirectPC and flush
//   RedirectPC        : redirect target (low two bits ignored)
//   imem              : instruction-memory fetch bus (master side)
//   Instruction       : IF/ID instruction word
//   InstrPC, PCPlus4  : PC of Instruction and PC+4
//   InstrValid        : Instruction is a real fetched word
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request up, waiting for or taking acks
// HOLD  | skid full while decode stalls, request down
module instruction_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [31:0]        NOP_INSTR = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Stall,
  input  logic                  Redirect,
  input  logic [ADDR_W-1:0]     RedirectPC,
  instruction_fetch_unit_if.master imem,
  output logic [31:0]           Instruction,
  output logic [ADDR_W-1:0]     InstrPC,
  output logic [ADDR_W-1:0]     PCPlus4,
  output logic                  InstrValid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]       instr_d;
  logic [ADDR_W-1:0] instr_pc_d, pc_plus4_d;
  logic              valid_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              accept;

  assign imem.ImemAddr = pc_q & ALIGN_MASK;
  assign imem.ImemReq  = (state_q == REQ);
  assign accept        = imem.ImemReq & imem.ImemAck;
  // wraps modulo 2^ADDR_W
  assign pc_plus4      = pc_q + ADDR_W'(4);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = Instruction;
    instr_pc_d   = InstrPC;
    pc_plus4_d   = PCPlus4;
    valid_d      = InstrValid;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (Redirect) begin
      // flush wins over stall and any same-cycle ack; the skid entry is
      // dropped simply by leaving HOLD, it is never read outside HOLD
      pc_d    = RedirectPC & ALIGN_MASK;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = REQ;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (!Stall) begin
            if (accept) begin
              instr_d    = imem.ImemRdata;
              instr_pc_d = pc_q;
              pc_plus4_d = pc_plus4;
              valid_d    = 1'b1;
              pc_d       = pc_plus4;
            end else begin
              instr_d = NOP_INSTR;
              valid_d = 1'b0;
            end
          end else if (accept) begin
            skid_instr_d = imem.ImemRdata;
            skid_pc_d    = pc_q;
            pc_d         = pc_plus4;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (!Stall) begin
            instr_d    = skid_instr_q;
            instr_pc_d = skid_pc_q;
            pc_plus4_d = skid_pc_q + ADDR_W'(4);
            valid_d    = 1'b1;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q         <= RESET_PC;
      Instruction  <= NOP_INSTR;
      InstrPC      <= '0;
      PCPlus4      <= '0;
      InstrValid   <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      Instruction  <= instr_d;
      InstrPC      <= instr_pc_d;
      PCPlus4      <= pc_plus4_d;
      InstrValid   <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Memory model: mem[a] = a ^ A5A5_0000,
// ack controlled per cycle. Instance a uses RESET_PC=0, instance b uses
// RESET_PC=FFFF_FFFC with a zero-wait memory to cover PC wrap.
module tb_instruction_fetch_unit;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall, Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] instr_a, pc_a, p4_a, instr_b, pc_b, p4_b;
  logic        valid_a, valid_b;
  int          n_checks = 0;
  int          n_errors = 0;

  instruction_fetch_unit_if #(.ADDR_W(32)) ifa ();
  instruction_fetch_unit_if #(.ADDR_W(32)) ifb ();

  assign ifa.ImemRdata = ifa.ImemAddr ^ 32'hA5A5_0000;
  assign ifb.ImemRdata = ifb.ImemAddr ^ 32'hA5A5_0000;

  instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut_a (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .imem(ifa.master), .Instruction(instr_a),
    .InstrPC(pc_a), .PCPlus4(p4_a), .InstrValid(valid_a));

  instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .Clk(Clk), .Rst(Rst), .Stall(1'b0), .Redirect(1'b0),
    .RedirectPC(32'h0), .imem(ifb.master), .Instruction(instr_b),
    .InstrPC(pc_b), .PCPlus4(p4_b), .InstrValid(valid_b));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req"},   32'(ifa.ImemReq), 32'h0);
    chk({tag, " addr"},  ifa.ImemAddr,     32'h0);
    chk({tag, " instr"}, instr_a,          32'h0);
    chk({tag, " valid"}, 32'(valid_a),     32'h0);
    chk({tag, " pc"},    pc_a,             32'h0);
    chk({tag, " pc4"},   p4_a,             32'h0);
  endtask

  initial begin
    Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    ifa.ImemAck = 1'b1;
    ifb.ImemAck = 1'b1;
    #2;
    chk_reset("rst");
    chk("rst b addr", ifb.ImemAddr, 32'hFFFF_FFFC);
    step(); step();
    Rst = 1'b0;

    // edge 1: IDLE -> REQ
    step();
    chk("e1 req", 32'(ifa.ImemReq), 32'h1);
    chk("e1 addr", ifa.ImemAddr, 32'h0);
    chk("e1 valid", 32'(valid_a), 32'h0);
    chk("e1 b addr", ifb.ImemAddr, 32'hFFFF_FFFC);

    // edge 2: first word delivered
    step();
    chk("e2 valid", 32'(valid_a), 32'h1);
    chk("e2 instr", instr_a, 32'hA5A5_0000);
    chk("e2 pc", pc_a, 32'h0);
    chk("e2 pc4", p4_a, 32'h4);
    chk("e2 addr", ifa.ImemAddr, 32'h4);
    chk("b wrap pc", pc_b, 32'hFFFF_FFFC);
    chk("b wrap pc4", p4_b, 32'h0);
    chk("b wrap instr", instr_b, 32'h5A5A_FFFC);
    chk("b wrap addr", ifb.ImemAddr, 32'h0);

    // edge 3: back-to-back
    step();
    chk("e3 instr", instr_a, 32'hA5A5_0004);
    chk("e3 pc", pc_a, 32'h4);
    chk("e3 addr", ifa.ImemAddr, 32'h8);
    chk("b next pc", pc_b, 32'h0);
    chk("b next pc4", p4_b, 32'h4);
    ifa.ImemAck = 1'b0;

    // edge 4: no ack on address 8 -> bubble
    step();
    chk("wait valid", 32'(valid_a), 32'h0);
    chk("wait instr", instr_a, 32'h0);
    chk("wait req", 32'(ifa.ImemReq), 32'h1);
    chk("wait addr", ifa.ImemAddr, 32'h8);
    ifa.ImemAck = 1'b1;

    step();
    chk("late valid", 32'(valid_a), 32'h1);
    chk("late pc", pc_a, 32'h8);
    chk("late instr", instr_a, 32'hA5A5_0008);

    step();
    chk("e6 pc", pc_a, 32'hC);
    chk("e6 addr", ifa.ImemAddr, 32'h10);
    Stall = 1'b1;

    // word 0x10 accepted into skid while stalled
    step();
    chk("hold1 pc", pc_a, 32'hC);
    chk("hold1 instr", instr_a, 32'hA5A5_000C);
    chk("hold1 valid", 32'(valid_a), 32'h1);
    chk("hold1 req", 32'(ifa.ImemReq), 32'h0);
    step();
    chk("hold2 pc", pc_a, 32'hC);
    chk("hold2 req", 32'(ifa.ImemReq), 32'h0);
    Stall = 1'b0;

    step();
    chk("skid pc", pc_a, 32'h10);
    chk("skid instr", instr_a, 32'hA5A5_0010);
    chk("skid pc4", p4_a, 32'h14);
    chk("skid valid", 32'(valid_a), 32'h1);
    chk("resume req", 32'(ifa.ImemReq), 32'h1);
    chk("resume addr", ifa.ImemAddr, 32'h14);

    step();
    chk("after skid pc", pc_a, 32'h14);
    Stall = 1'b1;

    // skid fills with 0x18, then redirect while stalled
    step();
    chk("full req", 32'(ifa.ImemReq), 32'h0);
    chk("full pc", pc_a, 32'h14);
    Redirect = 1'b1; RedirectPC = 32'h0000_0043;

    step();
    chk("redir valid", 32'(valid_a), 32'h0);
    chk("redir instr", instr_a, 32'h0);
    chk("redir addr", ifa.ImemAddr, 32'h40);
    chk("redir req", 32'(ifa.ImemReq), 32'h1);
    Redirect = 1'b0; Stall = 1'b0;

    step();
    chk("tgt valid", 32'(valid_a), 32'h1);
    chk("tgt pc", pc_a, 32'h40);
    chk("tgt instr", instr_a, 32'hA5A5_0040);
    chk("tgt pc4", p4_a, 32'h44);
    // redirect while an ack lands: acked word for 0x44 is discarded
    Redirect = 1'b1; RedirectPC = 32'h0000_0100;

    step();
    chk("redir2 valid", 32'(valid_a), 32'h0);
    chk("redir2 addr", ifa.ImemAddr, 32'h100);
    Redirect = 1'b0;

    step();
    chk("redir2 pc", pc_a, 32'h100);
    chk("redir2 instr", instr_a, 32'hA5A5_0100);

    // reset pulse while request at 0x104 is being acked
    #2;
    Rst = 1'b1;
    #2;
    chk_reset("midrst");
    step();
    Rst = 1'b0;

    step();
    chk("rst2 req", 32'(ifa.ImemReq), 32'h1);
    chk("rst2 addr", ifa.ImemAddr, 32'h0);
    chk("rst2 valid", 32'(valid_a), 32'h0);
    chk("rst2 pc", pc_a, 32'h0);

    step();
    chk("rst2 first valid", 32'(valid_a), 32'h1);
    chk("rst2 first pc", pc_a, 32'h0);
    chk("rst2 first instr", instr_a, 32'hA5A5_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
